// File: rtl/data_mem_ctrl.sv
// Data memory controller: byte/half/word loads and stores behind a req/resp handshake with WAIT_CYCLES wait states.
// Optional feature macro DMEM_MISALIGN_TRAP_EN: when defined, misaligned accesses fault instead of being force-aligned.
module data_mem_ctrl #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              Req,
  output logic              Ready,
  input  logic              MemWrite,
  input  logic [1:0]        Size,
  input  logic              Unsigned,
  input  logic [ADDR_W-1:0] Address,
  input  logic [31:0]       WriteData,
  output logic              RespValid,
  output logic [31:0]       ReadData,
  output logic              Fault
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic              write_q;
  logic              uns_q;
  logic [1:0]        size_q;
  logic [IDX_W+1:0]  addr_q;
  logic [31:0]       wdata_q;

  logic [31:0]       mem [DEPTH_WORDS];

  logic              access;
  logic              commit;
  logic              fault_next;
  logic [1:0]        lane;
  logic [IDX_W-1:0]  idx;
  logic [3:0]        be;
  logic [31:0]       wword;
  logic [31:0]       rword;
  logic [31:0]       shifted;
  logic [31:0]       load_val;

  // Upper address bits only matter for wrap-around, which happens by simply not using them.
  generate
    if (ADDR_W > IDX_W + 2) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^Address[ADDR_W-1:IDX_W+2];
    end
  endgenerate

  assign Ready  = (state == IDLE);
  assign access = (state == BUSY) && (cnt == 4'd0);
  assign commit = access && write_q && !fault_next;

  always_comb begin
    idx  = addr_q[IDX_W+1:2];
    lane = addr_q[1:0];
`ifdef DMEM_MISALIGN_TRAP_EN
    fault_next = ((size_q == 2'b01) && addr_q[0]) || (size_q[1] && (addr_q[1:0] != 2'b00));
`else
    fault_next = 1'b0;
    if (size_q == 2'b01)
      lane[0] = 1'b0;
    else if (size_q[1])
      lane = 2'b00;
`endif
    case (size_q)
      2'b00: begin
        be    = 4'b0001 << lane;
        wword = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be    = 4'b0011 << lane;
        wword = {2{wdata_q[15:0]}};
      end
      default: begin
        be    = '1;
        wword = wdata_q;
      end
    endcase
    rword   = mem[idx];
    shifted = rword >> {lane, 3'b000};
    case (size_q)
      2'b00:   load_val = {{24{!uns_q && shifted[7]}}, shifted[7:0]};
      2'b01:   load_val = {{16{!uns_q && shifted[15]}}, shifted[15:0]};
      default: load_val = rword;
    endcase
  end

  // Storage is not reset; the write is gated by state, so a reset before the access edge drops the store.
  always_ff @(posedge Clock) begin
    if (commit) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be[b])
          mem[idx][8*b +: 8] <= wword[8*b +: 8];
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      write_q   <= 1'b0;
      uns_q     <= 1'b0;
      size_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      RespValid <= 1'b0;
      ReadData  <= '0;
      Fault     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          RespValid <= 1'b0;
          if (Req) begin
            write_q <= MemWrite;
            uns_q   <= Unsigned;
            size_q  <= Size;
            addr_q  <= Address[IDX_W+1:0];
            wdata_q <= WriteData;
            cnt     <= 4'(WAIT_CYCLES);
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            RespValid <= 1'b1;
            ReadData  <= (write_q || fault_next) ? '0 : load_val;
            Fault     <= fault_next;
            state     <= RESP;
          end
        end
        RESP: begin
          RespValid <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          RespValid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
